// File: rtl/cache_pkg.sv
// Shared types and result packing for the cache read-result pipeline.
// The result layout is fixed: hit flag, reserved zeros, selected word, full line.
package cache_pkg;

  localparam int RESULT_W = 109;
  localparam int HIT_BIT  = 108;
  localparam int WORD_MSB = 95;
  localparam int WORD_LSB = 64;
  localparam int LINE_MSB = 63;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    DRAIN
  } state_t;

  function automatic logic [RESULT_W-1:0] pack_result(
    input logic        hit,
    input logic [31:0] word,
    input logic [63:0] line
  );
    logic [RESULT_W-1:0] r;
    r                     = '0;
    r[HIT_BIT]            = hit;
    r[WORD_MSB:WORD_LSB]  = word;
    r[LINE_MSB:0]         = line;
    return r;
  endfunction

endpackage

// File: rtl/cache_tag_data_array.sv
// Direct-mapped storage: per-set valid bit, tag and line, all in flops.
// Combinational read by index, synchronous single-port write, bulk invalidate.
module cache_tag_data_array #(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 25,
  parameter int LINE_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              inv_all,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= '0;
    end else begin
      if (we) valid_q[wr_idx] <= 1'b1;
      // NOTE: the later non-blocking assignment wins, so a coincident
      // invalidate leaves the freshly written line invalid.
      if (inv_all) valid_q <= '0;
    end
  end

  // NOTE: tag and line storage carry no reset; the valid bits alone gate use.
  always_ff @(posedge CLK) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      line_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = line_q[rd_idx];

endmodule

// File: rtl/cache_read_responder.sv
// Read responder: direct-mapped lookup with single-outstanding miss fill,
// producing a registered 109-bit result and one-cycle valid pulse.
module cache_read_responder
  import cache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                flush,
  input  logic                inv_all,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [LINE_W-1:0]   mem_resp_data,
  output logic [RESULT_W-1:0] Cache_result_o,
  output logic [ADDR_W-1:0]   ReadAddr_o,
  output logic                r_valid_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;

  state_t              state;
  logic [ADDR_W-1:0]   cap_addr;
  logic                lookup_armed;
  logic                rd_valid_q;
  logic [TAG_W-1:0]    rd_tag_q;
  logic [LINE_W-1:0]   rd_line_q;

  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [LINE_W-1:0]   arr_line;
  logic                arr_we;
  logic [IDX_W-1:0]    cap_idx;
  logic [TAG_W-1:0]    cap_tag;
  logic                hit;
  logic [31:0]         hit_word;
  logic [31:0]         fill_word;

  assign cap_idx   = cap_addr[2+IDX_W:3];
  assign cap_tag   = cap_addr[ADDR_W-1:3+IDX_W];
  assign hit       = rd_valid_q && (rd_tag_q == cap_tag);
  assign hit_word  = cap_addr[2] ? rd_line_q[63:32] : rd_line_q[31:0];
  assign fill_word = cap_addr[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
  assign arr_we    = mem_resp_valid && ((state == MISS_WAIT) || (state == DRAIN));
  assign req_ready = (state == IDLE);

  cache_tag_data_array #(
    .SETS   (SETS),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_array (
    .CLK      (CLK),
    .RESET    (RESET),
    .inv_all  (inv_all),
    .rd_idx   (cap_idx),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_line  (arr_line),
    .we       (arr_we),
    .wr_idx   (cap_idx),
    .wr_tag   (cap_tag),
    .wr_line  (mem_resp_data)
  );

  // LOOKUP spans two cycles: the first registers the array read, the second
  // compares and either delivers the hit or launches the fill.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      cap_addr       <= '0;
      lookup_armed   <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_tag_q       <= '0;
      rd_line_q      <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
      Cache_result_o <= '0;
      ReadAddr_o     <= '0;
      r_valid_o      <= 1'b0;
    end else begin
      r_valid_o <= 1'b0;
      if (flush) begin
        Cache_result_o <= '0;
        ReadAddr_o     <= '0;
      end
      unique case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            cap_addr     <= req_addr;
            lookup_armed <= 1'b0;
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) begin
            state <= IDLE;
          end else if (!lookup_armed) begin
            lookup_armed <= 1'b1;
            rd_valid_q   <= arr_valid;
            rd_tag_q     <= arr_tag;
            rd_line_q    <= arr_line;
          end else if (hit) begin
            Cache_result_o <= pack_result(1'b1, hit_word, rd_line_q);
            ReadAddr_o     <= cap_addr;
            r_valid_o      <= 1'b1;
            state          <= IDLE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {cap_addr[ADDR_W-1:3], 3'b000};
            state         <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= flush ? DRAIN : MISS_WAIT;
          end else if (flush) begin
            mem_req_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        MISS_WAIT: begin
          if (mem_resp_valid) begin
            state <= IDLE;
            if (!flush) begin
              Cache_result_o <= pack_result(1'b0, fill_word, mem_resp_data);
              ReadAddr_o     <= cap_addr;
              r_valid_o      <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_read_responder.md
Name: cache_read_responder

Overview:
- Producer side of the cache read-result pipeline interface: accepts fetch/load read requests and looks them up in a small direct-mapped cache.
- Fills the cache from memory on a miss.
- Drives the 109-bit result, the request address and the valid pulse consumed by the downstream result pipeline register.
- Shares the same flush signal as the downstream register, so squashed requests never produce a result.

Parameters:
- SETS, 16, number of direct-mapped lines (power of two, >= 2)
- ADDR_W, 32, request/memory address width
- LINE_W, 64, line width in bits (two 32-bit words; fixed by the result packing)

Ports:
- CLK  input  1  clock
- RESET  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous squash of the in-flight request
- inv_all  input  1  synchronous invalidate of all lines
- req_valid  input  1  read request valid
- req_addr  input  32  byte address of requested word (bits [1:0] ignored)
- req_ready  output  1  high only in IDLE
- mem_req_valid  output  1  line fetch request
- mem_req_addr  output  32  line-aligned address, req_addr with [2:0] = 0
- mem_req_ready  input  1  memory accepts request
- mem_resp_valid  input  1  fill data valid, single beat
- mem_resp_data  input  64  fill line
- Cache_result_o  output  109  packed result
- ReadAddr_o  output  32  address of the completed request
- r_valid_o  output  1  one-cycle result valid pulse

Behaviour:
- Address split: offset [2:0]; index [2+log2(SETS):3]; tag is the remaining upper bits.
- Word select: addr[2] (0 = line[31:0], 1 = line[63:32]).
- Result packing:
  - [108] = hit flag (1 = served without fill)
  - [107:96] = 0
  - [95:64] = selected word
  - [63:0] = full line
- Storage: per set, one valid bit, tag and line, all in flops.
- Reset: state IDLE, all valid bits 0. Outputs are 0: Cache_result_o, ReadAddr_o, r_valid_o, mem_req_valid, mem_req_addr. req_ready is 1.
- All outputs are registered except req_ready.
- States and transitions:
  - IDLE: req_valid & req_ready captures req_addr -> LOOKUP.
  - LOOKUP: tag compare on the captured address.
    - Hit: register result with [108] = 1, ReadAddr_o = captured address, r_valid_o = 1 for one cycle -> IDLE.
    - Miss -> MISS_REQ.
  - MISS_REQ: mem_req_valid = 1 and mem_req_addr stable until mem_req_ready -> MISS_WAIT.
  - MISS_WAIT: wait for mem_resp_valid; write line, tag and valid bit, and register the result with [108] = 0 and r_valid_o = 1 -> IDLE.
  - DRAIN: wait for mem_resp_valid; write the line into the array, no result -> IDLE.
- Latency, counting from the accept edge E:
  - Hit: r_valid_o is high in the cycle after edge E+2.
  - Miss: r_valid_o is high in the cycle after the mem_resp_valid edge.
- r_valid_o is never high for two consecutive cycles; back-to-back requests are spaced by at least 2 cycles.
- Memory interface:
  - At most one outstanding fetch.
  - mem_resp_valid outside MISS_WAIT/DRAIN is ignored.
- Flush (priority over all other transitions):
  - IDLE or LOOKUP -> IDLE, no r_valid_o; a request presented in the same cycle is not accepted.
  - MISS_REQ without mem_req_ready -> IDLE.
  - MISS_REQ with mem_req_ready in the same cycle -> DRAIN.
  - MISS_WAIT -> DRAIN. If mem_resp_valid arrives in the same cycle, the line is written, no r_valid_o, -> IDLE.
  - Flush in the cycle a result would be registered suppresses r_valid_o. Cache_result_o and ReadAddr_o are cleared to 0 on flush.
- inv_all:
  - Clears every valid bit at the next edge.
  - Coincident with a fill write, inv_all wins: the line is not valid afterwards, but the result is still delivered.
  - Coincident with a LOOKUP, the lookup uses the pre-clear valid bits.
- Reset asserted mid-miss: return to the reset state. A memory response arriving later is ignored (state IDLE).

Decomposition:
- Shared package cache_pkg:
  - Result field positions: HIT_BIT = 108, WORD_MSB = 95, WORD_LSB = 64, LINE_MSB = 63.
  - RESULT_W = 109.
  - State enum {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, DRAIN}.
  - Function pack_result(hit, word, line).
- One sub-module: cache_tag_data_array, holding valid/tag/line flops.
  - Combinational read by index.
  - Synchronous write.
  - inv_all clear.

Test Plan:
- Cold miss: req 0x0000_1004 -> mem_req_addr 0x0000_1000; respond with 0x89ABCDEF_01234567 -> r_valid_o one cycle, Cache_result_o[108] = 0, [95:64] = 0x89ABCDEF, ReadAddr_o = 0x0000_1004.
- Hit after fill: req 0x0000_1000 -> no mem_req_valid; r_valid_o in the cycle after edge E+2; [108] = 1, [95:64] = 0x01234567.
- Conflict: req 0x0000_1080 (same index, different tag) -> miss with mem_req_addr 0x0000_1080; a subsequent req 0x0000_1000 misses again.
- Flush in MISS_WAIT: flush, then mem_resp_valid 3 cycles later -> no r_valid_o, req_ready stays low until the response, then a req to the same address hits with [108] = 1.
- Flush in MISS_REQ without mem_req_ready -> req_ready high next cycle; a late mem_resp_valid is ignored and the array is unchanged.
- inv_all after fill, then req 0x0000_1000 -> miss and a new mem_req. Reset asserted in MISS_WAIT -> all outputs 0 and req_ready = 1 immediately.
